// File: rtl/adder_error_monitor_if.sv
// Sample-pair stream from the adder stage into the error monitor.
//   in_valid  : producer has a {exact_y, approx_y} pair this cycle
//   in_ready  : monitor accepts the pair this cycle
//   exact_y   : result of the exact reference adder
//   approx_y  : result of the approximate adder under test
// Modports: master = sample producer, slave = monitor.
interface adder_error_monitor_if #(
    parameter int unsigned WIDTH = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] exact_y;
    logic [WIDTH-1:0] approx_y;

    modport master (
        output in_valid,
        output exact_y,
        output approx_y,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  exact_y,
        input  approx_y,
        output in_ready
    );
endinterface

// File: rtl/adder_error_monitor.sv
// Error-statistics monitor for approximate adders. It accumulates, over a window
// of WINDOW accepted sample pairs, the sample count, the number of erroneous
// samples, the saturating sum of error distance |exact_y - approx_y| and the
// maximum error distance.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : clears the stats and opens a window (honoured in IDLE/DONE only)
//   bus (slave)   : sample pair stream (in_valid/in_ready/exact_y/approx_y)
//   busy          : window in progress (RUN or DRAIN)
//   done          : window complete, stats stable until the next start
//   sample_count  : samples accepted in this window
//   err_count     : samples with exact_y != approx_y
//   sum_ed        : saturating sum of error distance
//   max_ed        : largest error distance seen
//   ham_sum       : saturating sum of popcount(exact_y ^ approx_y), present only
//                   when AEM_HAMMING_EN is defined
//
// Timing: a transfer bumps sample_count on its own edge, the error distance is
// registered in S1 on that edge, and the remaining stats update on the next edge.
module adder_error_monitor #(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned WINDOW = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    adder_error_monitor_if.slave  bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      sample_count,
    output logic [CNT_W-1:0]      err_count,
    output logic [ACC_W-1:0]      sum_ed,
    output logic [WIDTH-1:0]      max_ed
`ifdef AEM_HAMMING_EN
    ,
    output logic [ACC_W-1:0]      ham_sum
`endif
);

    localparam int unsigned DIFF_W = WIDTH + 1;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic ready_c;
    logic xfer;
    logic last_xfer;
    logic clear;

    logic [DIFF_W-1:0] diff;
    logic [DIFF_W-1:0] diff_neg;
    logic [WIDTH-1:0]  ed_c;
    logic              neq_c;

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_ed;
    logic              s1_neq;

    logic [SUM_W-1:0]  ed_sum_wide;
    logic [ACC_W-1:0]  ed_sum_sat;

`ifdef AEM_HAMMING_EN
    localparam int unsigned POP_W = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] xor_c;
    logic [POP_W-1:0] pop_c;
    logic [POP_W-1:0] s1_pop;
    logic [SUM_W-1:0] ham_sum_wide;
    logic [ACC_W-1:0] ham_sum_sat;
`endif

    // Handshake and window bookkeeping
    assign bus.in_ready = ready_c;
    assign xfer         = bus.in_valid & ready_c;
    assign last_xfer    = xfer && (sample_count == LAST_IDX);
    assign clear        = start && ((state == S_IDLE) || (state == S_DONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DRAIN waits for S1 to empty, which takes exactly 2 cycles
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)      state_nxt = S_RUN;
            S_RUN:   if (last_xfer)  state_nxt = S_DRAIN;
            S_DRAIN: if (!s1_valid)  state_nxt = S_DONE;
            S_DONE:  if (start)      state_nxt = S_RUN;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        ready_c = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_RUN: begin
                ready_c = 1'b1;
                busy    = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Error distance: zero-extended subtract, then absolute value
    always_comb begin
        diff     = DIFF_W'(bus.exact_y) - DIFF_W'(bus.approx_y);
        diff_neg = ~diff + DIFF_W'(1);
        ed_c     = diff[WIDTH] ? diff_neg[WIDTH-1:0] : diff[WIDTH-1:0];
        neq_c    = (bus.exact_y != bus.approx_y);
    end

`ifdef AEM_HAMMING_EN
    // Hamming distance between the two results
    always_comb begin
        xor_c = bus.exact_y ^ bus.approx_y;
        pop_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop_c = pop_c + POP_W'(xor_c[i]);
        end
    end
`endif

    // S1: register per-sample error metrics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
            s1_neq   <= 1'b0;
`ifdef AEM_HAMMING_EN
            s1_pop   <= '0;
`endif
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_ed  <= ed_c;
                s1_neq <= neq_c;
`ifdef AEM_HAMMING_EN
                s1_pop <= pop_c;
`endif
            end
        end
    end

    // Saturating accumulators; the extra top bit is the overflow indicator
    always_comb begin
        ed_sum_wide = SUM_W'(sum_ed) + SUM_W'(s1_ed);
        ed_sum_sat  = ed_sum_wide[ACC_W] ? '1 : ed_sum_wide[ACC_W-1:0];
`ifdef AEM_HAMMING_EN
        ham_sum_wide = SUM_W'(ham_sum) + SUM_W'(s1_pop);
        ham_sum_sat  = ham_sum_wide[ACC_W] ? '1 : ham_sum_wide[ACC_W-1:0];
`endif
    end

    // S2: statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
`ifdef AEM_HAMMING_EN
            ham_sum      <= '0;
`endif
        end else if (clear) begin
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
`ifdef AEM_HAMMING_EN
            ham_sum      <= '0;
`endif
        end else begin
            if (xfer) begin
                sample_count <= sample_count + CNT_W'(1);
            end
            if (s1_valid) begin
                // err_count is bounded by WINDOW, so it cannot wrap
                if (s1_neq) begin
                    err_count <= err_count + CNT_W'(1);
                end
                sum_ed <= ed_sum_sat;
                if (s1_ed > max_ed) begin
                    max_ed <= s1_ed;
                end
`ifdef AEM_HAMMING_EN
                ham_sum <= ham_sum_sat;
`endif
            end
        end
    end

endmodule
